// File: rtl/commit_trace_buffer.sv
// Commit trace capture: timestamps up to two retiring instructions per cycle into a
// small FIFO drained over valid/ready, with drop counting and in-order overflow markers.
module commit_trace_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            commit_valid_i,
    input  logic [1:0][63:0]      commit_pc_i,
    input  logic [1:0][31:0]      commit_instr_i,
    input  logic [1:0][4:0]       commit_rd_i,
    input  logic [1:0]            commit_we_i,
    input  logic [1:0][63:0]      commit_wdata_i,
    input  logic [1:0]            priv_lvl_i,
    output logic                  trace_valid_o,
    input  logic                  trace_ready_i,
    output logic                  trace_kind_o,
    output logic                  trace_port_o,
    output logic [TS_W-1:0]       trace_ts_o,
    output logic [63:0]           trace_pc_o,
    output logic [31:0]           trace_instr_o,
    output logic [4:0]            trace_rd_o,
    output logic                  trace_we_o,
    output logic [63:0]           trace_wdata_o,
    output logic [1:0]            trace_priv_o,
    output logic [31:0]           drop_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic            kind;
        logic            port;
        logic [TS_W-1:0] ts;
        logic [63:0]     pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic            we;
        logic [63:0]     wdata;
        logic [1:0]      priv;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [TS_W-1:0]  ts_q;
    logic             pending_q;
    logic [15:0]      lost_q;
    logic [31:0]      drop_count_q;

    logic [CNT_W-1:0] space;
    entry_t           wr_ent [4];
    logic [1:0]       n_wr;
    logic [1:0]       n_drop;
    logic             mark_wr;
    logic             pop;
    logic             pending_d;
    logic [15:0]      lost_base;
    logic [16:0]      lost_sum;
    logic [15:0]      lost_d;
    logic [32:0]      drop_sum;
    logic [31:0]      drop_count_d;
    entry_t           head;

    assign trace_valid_o = (count_q != '0);
    assign pop           = trace_valid_o & trace_ready_i;

    // Grant writes in priority order (marker, port 0, port 1) against start-of-cycle space
    always_comb begin
        space   = CNT_W'(DEPTH) - count_q;
        n_wr    = 2'd0;
        n_drop  = 2'd0;
        mark_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_ent[i] = '0;
        end
        if (pending_q && (space != '0)) begin
            mark_wr         = 1'b1;
            wr_ent[0].kind  = 1'b1;
            wr_ent[0].priv  = priv_lvl_i;
            wr_ent[0].ts    = ts_q;
            wr_ent[0].wdata = 64'(lost_q);
            n_wr            = 2'd1;
        end
        for (int p = 0; p < 2; p++) begin
            if (commit_valid_i[p]) begin
                if (CNT_W'(n_wr) < space) begin
                    wr_ent[n_wr].kind  = 1'b0;
                    wr_ent[n_wr].port  = 1'(p);
                    wr_ent[n_wr].ts    = ts_q;
                    wr_ent[n_wr].pc    = commit_pc_i[p];
                    wr_ent[n_wr].instr = commit_instr_i[p];
                    wr_ent[n_wr].rd    = commit_rd_i[p];
                    wr_ent[n_wr].we    = commit_we_i[p];
                    wr_ent[n_wr].wdata = commit_wdata_i[p];
                    wr_ent[n_wr].priv  = priv_lvl_i;
                    n_wr               = n_wr + 2'd1;
                end else begin
                    n_drop = n_drop + 2'd1;
                end
            end
        end
    end

    // Saturating loss accounting; a written marker restarts the loss run
    always_comb begin
        drop_sum     = {1'b0, drop_count_q} + 33'(n_drop);
        drop_count_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        lost_base    = mark_wr ? 16'd0 : lost_q;
        lost_sum     = {1'b0, lost_base} + 17'(n_drop);
        lost_d       = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
        pending_d    = (pending_q & ~mark_wr) | (n_drop != 2'd0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ts_q         <= '0;
            pending_q    <= 1'b0;
            lost_q       <= '0;
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) < n_wr) begin
                    mem_q[wr_ptr_q + PTR_W'(i)] <= wr_ent[i];
                end
            end
            wr_ptr_q     <= wr_ptr_q + PTR_W'(n_wr);
            rd_ptr_q     <= rd_ptr_q + PTR_W'(pop);
            count_q      <= count_q + CNT_W'(n_wr) - CNT_W'(pop);
            ts_q         <= ts_q + TS_W'(1);
            pending_q    <= pending_d;
            lost_q       <= lost_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign trace_kind_o  = head.kind;
    assign trace_port_o  = head.port;
    assign trace_ts_o    = head.ts;
    assign trace_pc_o    = head.pc;
    assign trace_instr_o = head.instr;
    assign trace_rd_o    = head.rd;
    assign trace_we_o    = head.we;
    assign trace_wdata_o = head.wdata;
    assign trace_priv_o  = head.priv;
    assign drop_count_o  = drop_count_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized and directed bench for commit_trace_buffer against a queue-based trace model.
module tb_commit_trace_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       cv = '0;
    logic [1:0][63:0] cpc = '0;
    logic [1:0][31:0] cinstr = '0;
    logic [1:0][4:0]  crd = '0;
    logic [1:0]       cwe = '0;
    logic [1:0][63:0] cwd = '0;
    logic [1:0]       priv = '0;
    logic             ready = 1'b0;

    logic             trace_valid;
    logic             trace_kind;
    logic             trace_port;
    logic [TS_W-1:0]  trace_ts;
    logic [63:0]      trace_pc;
    logic [31:0]      trace_instr;
    logic [4:0]       trace_rd;
    logic             trace_we;
    logic [63:0]      trace_wdata;
    logic [1:0]       trace_priv;
    logic [31:0]      drop_count;

    commit_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .commit_valid_i (cv),
        .commit_pc_i    (cpc),
        .commit_instr_i (cinstr),
        .commit_rd_i    (crd),
        .commit_we_i    (cwe),
        .commit_wdata_i (cwd),
        .priv_lvl_i     (priv),
        .trace_valid_o  (trace_valid),
        .trace_ready_i  (ready),
        .trace_kind_o   (trace_kind),
        .trace_port_o   (trace_port),
        .trace_ts_o     (trace_ts),
        .trace_pc_o     (trace_pc),
        .trace_instr_o  (trace_instr),
        .trace_rd_o     (trace_rd),
        .trace_we_o     (trace_we),
        .trace_wdata_o  (trace_wdata),
        .trace_priv_o   (trace_priv),
        .drop_count_o   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            kind;
        logic            port;
        logic [TS_W-1:0] ts;
        logic [63:0]     pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic            we;
        logic [63:0]     wdata;
        logic [1:0]      priv;
    } m_ent_t;

    m_ent_t          m_q[$];
    logic [TS_W-1:0] m_ts;
    bit              m_pending;
    longint          m_lost;
    longint          m_drop;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts      = '0;
        m_pending = 1'b0;
        m_lost    = 0;
        m_drop    = 0;
    endtask

    // One clock of trace capture: space is judged before this cycle's pop
    task automatic model_step();
        int     space;
        int     dn;
        bit     mark;
        m_ent_t e;
        m_ent_t adds[$];
        space = int'(DEPTH) - m_q.size();
        dn    = 0;
        mark  = 1'b0;
        if (m_pending && space > 0) begin
            e       = '0;
            e.kind  = 1'b1;
            e.ts    = m_ts;
            e.priv  = priv;
            e.wdata = 64'(m_lost);
            adds.push_back(e);
            space--;
            mark = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            if (cv[p]) begin
                if (space > 0) begin
                    e       = '0;
                    e.port  = 1'(p);
                    e.ts    = m_ts;
                    e.pc    = cpc[p];
                    e.instr = cinstr[p];
                    e.rd    = crd[p];
                    e.we    = cwe[p];
                    e.wdata = cwd[p];
                    e.priv  = priv;
                    adds.push_back(e);
                    space--;
                end else begin
                    dn++;
                end
            end
        end
        if (m_q.size() > 0 && ready) void'(m_q.pop_front());
        foreach (adds[i]) m_q.push_back(adds[i]);
        m_drop = (m_drop + dn > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_drop + dn;
        if (mark) begin
            m_lost    = dn;
            m_pending = (dn > 0);
        end else begin
            m_lost    = (m_lost + dn > 65535) ? 65535 : m_lost + dn;
            m_pending = m_pending || (dn > 0);
        end
        m_ts = m_ts + 1'b1;
    endtask

    function automatic logic [255:0] head_obs();
        m_ent_t h;
        h.kind  = trace_kind;
        h.port  = trace_port;
        h.ts    = trace_ts;
        h.pc    = trace_pc;
        h.instr = trace_instr;
        h.rd    = trace_rd;
        h.we    = trace_we;
        h.wdata = trace_wdata;
        h.priv  = trace_priv;
        return 256'(h);
    endfunction

    task automatic compare_all();
        check("valid", 256'(trace_valid), 256'(m_q.size() != 0));
        if (m_q.size() != 0) check("head", head_obs(), 256'(m_q[0]));
        check("drop_count", 256'(drop_count), 256'(m_drop));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_commit(input int pv);
        for (int p = 0; p < 2; p++) begin
            cv[p]     = ($urandom_range(99) < pv);
            cpc[p]    = {$urandom, $urandom};
            cinstr[p] = $urandom;
            crd[p]    = 5'($urandom);
            cwe[p]    = 1'($urandom);
            cwd[p]    = {$urandom, $urandom};
        end
        priv = 2'($urandom);
    endtask

    task automatic set_commit(input int p, input logic [63:0] pc, input logic [4:0] rd,
                              input logic we, input logic [63:0] wd);
        cv[p]     = 1'b1;
        cpc[p]    = pc;
        cinstr[p] = $urandom;
        crd[p]    = rd;
        cwe[p]    = we;
        cwd[p]    = wd;
    endtask

    task automatic do_reset_mid();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 256'(trace_valid), 256'(0));
        check("rst_drop", 256'(drop_count), 256'(0));
        check("rst_head", head_obs(), 256'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check("init_valid", 256'(trace_valid), 256'(0));
        check("init_head", head_obs(), 256'(0));
        check("init_drop", 256'(drop_count), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single commit captured at ts=5
        ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        set_commit(0, 64'h8000_0000, 5'd5, 1'b1, 64'h2A);
        cycle();
        cv = '0;
        check("single_ts", 256'(trace_ts), 256'(5));
        check("single_pc", 256'(trace_pc), 256'(64'h8000_0000));
        check("single_wdata", 256'(trace_wdata), 256'(64'h2A));
        check("single_kind", 256'({trace_kind, trace_port}), 256'(0));
        cycle();
        check("single_empty", 256'(trace_valid), 256'(0));

        // Dual commit at ts=9 pops in port order
        while (m_ts != 8'd9) cycle();
        set_commit(0, 64'h100, 5'd1, 1'b0, 64'h0);
        set_commit(1, 64'h104, 5'd2, 1'b1, 64'h7);
        cycle();
        cv = '0;
        check("dual0", 256'({trace_port, trace_ts, trace_pc}), 256'({1'b0, 8'd9, 64'h100}));
        cycle();
        check("dual1", 256'({trace_port, trace_ts, trace_pc}), 256'({1'b1, 8'd9, 64'h104}));
        cycle();

        // Queue 3 entries, then reset asynchronously; ts restarts at 0
        ready = 1'b0;
        rand_commit(0);
        set_commit(0, 64'h200, 5'd3, 1'b1, 64'h11);
        set_commit(1, 64'h204, 5'd4, 1'b1, 64'h12);
        cycle();
        cv[1] = 1'b0;
        cycle();
        cv = '0;
        do_reset_mid();
        set_commit(0, 64'h300, 5'd6, 1'b1, 64'h13);
        cycle();
        cv = '0;
        check("ts_restart", 256'(trace_ts), 256'(0));

        // Overflow: three dual commits into an empty 4-deep FIFO, then drain under load
        do_reset_mid();
        for (int i = 0; i < 3; i++) begin
            rand_commit(100);
            cycle();
        end
        check("ovf_drops", 256'(drop_count), 256'(2));
        ready = 1'b1;
        rand_commit(100);
        cycle();
        check("full_pop_drops", 256'(drop_count), 256'(4));
        for (int i = 0; i < 10; i++) begin
            rand_commit(100);
            cycle();
        end
        cv = '0;
        for (int i = 0; i < 8; i++) cycle();

        // Full with pop and a single commit: commit dropped, marker follows
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_commit(100);
            cycle();
        end
        ready = 1'b1;
        rand_commit(0);
        cv = 2'b01;
        cycle();
        cv = '0;
        for (int i = 0; i < 6; i++) cycle();

        // Port 1 only
        cv = 2'b00;
        set_commit(1, 64'h400, 5'd7, 1'b0, 64'h0);
        cycle();
        cv = '0;
        check("port1_only", 256'({trace_valid, trace_port, trace_pc}), 256'({1'b1, 1'b1, 64'h400}));
        cycle();

        // Randomized traffic with varying pressure, one reset midway; ts wraps
        for (int i = 0; i < 800; i++) begin
            rand_commit((i / 100) % 2 == 0 ? 70 : 30);
            ready = ($urandom_range(99) < ((i / 50) % 3 == 0 ? 20 : 80));
            cycle();
            if (i == 400) do_reset_mid();
        end
        cv = '0;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
